// File: rtl/stream_merge2.sv
// stream_merge2: two-input val/rdy merger, round-robin arbitration, registered output.
// Optional macro STREAM_MERGE2_SKID_EN selects a 2-entry skid FIFO output stage.
module stream_merge2 #(
    parameter int p_nbits = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in0_val,
    output logic               in0_rdy,
    input  logic [p_nbits-1:0] in0_msg,
    input  logic               in1_val,
    output logic               in1_rdy,
    input  logic [p_nbits-1:0] in1_msg,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] out_msg,
    output logic               out_src
);

    logic               prio;
    logic               grant;
    logic               can_accept;
    logic               enq;
    logic               deq;
    logic [p_nbits-1:0] enq_msg;

    // Round-robin grant: contention goes to prio, otherwise the lone requester.
    always_comb begin
        grant = in1_val;
        if (in0_val && in1_val) begin
            grant = prio;
        end
    end

    assign in0_rdy = can_accept && !grant;
    assign in1_rdy = can_accept && grant;
    assign enq     = (in0_val && in0_rdy) || (in1_val && in1_rdy);
    assign enq_msg = grant ? in1_msg : in0_msg;
    assign deq     = out_val && out_rdy;

    // Priority pointer flips away from the source that just transferred.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (enq) begin
            prio <= ~grant;
        end
    end

`ifdef STREAM_MERGE2_SKID_EN

    logic [1:0]         count;
    logic [p_nbits-1:0] tail_msg;
    logic               tail_src;

    // Readiness comes from registered occupancy only, so out_rdy never reaches in_rdy.
    assign can_accept = !reset && (count != 2'd2);

    // Two-entry FIFO: head is the output register, tail holds the skid entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= 2'd0;
            out_val  <= 1'b0;
            out_msg  <= '0;
            out_src  <= 1'b0;
            tail_msg <= '0;
            tail_src <= 1'b0;
        end else begin
            case ({enq, deq})
                2'b10: begin
                    if (count == 2'd0) begin
                        out_msg <= enq_msg;
                        out_src <= grant;
                    end else begin
                        tail_msg <= enq_msg;
                        tail_src <= grant;
                    end
                    out_val <= 1'b1;
                    count   <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        out_msg <= tail_msg;
                        out_src <= tail_src;
                    end
                    out_val <= (count == 2'd2);
                    count   <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        out_msg <= enq_msg;
                        out_src <= grant;
                    end else begin
                        out_msg  <= tail_msg;
                        out_src  <= tail_src;
                        tail_msg <= enq_msg;
                        tail_src <= grant;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`else

    // A full pipe register can still accept if it is draining this cycle.
    assign can_accept = !reset && (!out_val || out_rdy);

    // Single-entry pipe register feeding the consumer.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_val <= 1'b0;
            out_msg <= '0;
            out_src <= 1'b0;
        end else if (enq) begin
            out_val <= 1'b1;
            out_msg <= enq_msg;
            out_src <= grant;
        end else if (deq) begin
            out_val <= 1'b0;
        end
    end

`endif

endmodule
